wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock and one reset: the clock is clk, rising-edge; reset is rst, synchronous, active-high.
REQ-002 Port: clk  input  1  system clock (same clock as all wishbone ports).
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Ports m0_ADR/m1_ADR  input  12  requester line address (byte address [15:4]).
REQ-005 Ports m0_DAT_M/m1_DAT_M  input  128  requester write data.
REQ-006 Ports m0_SEL/m1_SEL  input  16  requester byte enables.
REQ-007 Ports m0_STB/m1_STB, m0_CYC/m1_CYC, m0_WE/m1_WE  input  1 each  requester strobe, cycle, write-enable.
REQ-008 Ports m0_ACK/m1_ACK, m0_RTY/m1_RTY  output  1 each  per-requester acknowledge, retry.
REQ-009 Ports m0_DAT_S/m1_DAT_S  output  128  read data returned to each requester.
REQ-010 Ports s_ADR 12, s_DAT_M 128, s_SEL 16, s_STB 1, s_CYC 1, s_WE 1  output  forwarded to the memory-side wishbone.
REQ-011 Ports s_DAT_S 128, s_ACK 1, s_RTY 1  input  memory-side response.
REQ-012 Parameter: none; widths fixed by the shared package.

Function
REQ-013 SHALL share the single memory-side wishbone bus between requester 0 (instruction cache) and requester 1 (eviction write-back cache).
REQ-014 Request for requester k SHALL be mk_CYC & mk_STB.
REQ-015 FSM states SHALL be IDLE, GRANT0, GRANT1; state and last_grant (1 bit) are registers.
REQ-016 IDLE: one request -> grant that requester next cycle; both -> grant the requester not equal to last_grant (round-robin); none -> stay IDLE.
REQ-017 On entering GRANTk, last_grant SHALL be set to k.
REQ-018 In GRANTk, s_ADR/s_DAT_M/s_SEL/s_WE/s_STB/s_CYC SHALL equal requester k's signals combinationally; in IDLE s_STB=s_CYC=s_WE=0, s_ADR=0, s_DAT_M=0, s_SEL=0.
REQ-019 In GRANTk, mk_ACK=s_ACK and mk_RTY=s_RTY combinationally; the other requester's ACK/RTY SHALL be 0; in IDLE all ACK/RTY are 0.
REQ-020 m0_DAT_S and m1_DAT_S SHALL both equal s_DAT_S at all times.
REQ-021 In GRANTk, s_ACK=1 or s_RTY=1 SHALL return the FSM to IDLE the next cycle (one transfer per grant; requester must drop STB the cycle after ACK).
REQ-022 In GRANTk, mk_CYC=0 (abort) SHALL return the FSM to IDLE the next cycle; s_CYC is 0 in that cycle via REQ-018.
REQ-023 Latency: request seen in IDLE at cycle n -> s_STB asserted in cycle n+1; minimum one IDLE cycle between consecutive grants.
REQ-024 A request arriving while the other requester is granted SHALL wait; no request is dropped; maximum wait is one full transaction of the other requester plus one cycle.
REQ-025 s_ACK/s_RTY asserted while IDLE SHALL be ignored (not forwarded).

Reset
REQ-026 rst=1 at a rising edge SHALL force state=IDLE, last_grant=1 (so requester 0 wins the first contention).
REQ-027 rst asserted mid-grant SHALL abandon the transfer: next cycle IDLE, all s_* control outputs and all ACK/RTY 0.
REQ-028 Reset SHALL take priority over every transition.

Structure
REQ-029 arb_state_t enum (IDLE, GRANT0, GRANT1) and wishbone address/data/select width constants SHALL live in lc3b_types.
REQ-030 One sub-module, wb_arb_mux (purely combinational grant-select of request fields and response routing), SHALL be instantiated; FSM stays in wb_arbiter.

Verification
REQ-031 Reset then m0 read ADR=12'h012, memory ACK after 3 cycles with DAT_S=128'hA5.. -> s_STB at cycle+1, m0_ACK one cycle, m1_ACK=0, FSM IDLE next cycle.
REQ-032 m0 and m1 request same cycle after reset -> m0 granted first; on m0 ACK, IDLE one cycle, then m1 granted (s_WE=m1_WE, s_ADR=m1_ADR).
REQ-033 Both requesting continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; neither starves.
REQ-034 Granted m1 write with SEL=16'h00FF, memory asserts RTY -> m1_RTY=1, m0_RTY=0, FSM IDLE next cycle, m1 re-granted on reissue.
REQ-035 m0 granted, m0_CYC dropped before ACK -> s_CYC=0 same cycle, IDLE next cycle, pending m1 granted following cycle.
REQ-036 rst pulsed during GRANT1 with memory stalled -> IDLE next cycle, all ACK/RTY 0, next contention granted to m0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared wishbone widths, request bundle and arbiter state encoding for the
// LC-3b memory hierarchy.
package lc3b_types;

  localparam int WB_ADR_W = 12;
  localparam int WB_DAT_W = 128;
  localparam int WB_SEL_W = 16;

  typedef logic [WB_ADR_W-1:0] wb_adr_t;
  typedef logic [WB_DAT_W-1:0] wb_dat_t;
  typedef logic [WB_SEL_W-1:0] wb_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Requester-to-memory fields that travel together through the grant mux.
  typedef struct packed {
    wb_adr_t adr;
    wb_dat_t dat;
    wb_sel_t sel;
    logic    we;
    logic    stb;
    logic    cyc;
  } wb_req_t;

  function automatic logic wb_request(input wb_req_t r);
    return r.cyc & r.stb;
  endfunction

endpackage

// File: rtl/wb_arb_mux.sv
// Combinational grant select: forwards the owning requester to the memory bus
// and routes ACK/RTY back only to that requester.
module wb_arb_mux
  import lc3b_types::*;
(
  input  arb_state_t state,
  input  wb_req_t    m0_req,
  input  wb_req_t    m1_req,
  input  logic       s_ack,
  input  logic       s_rty,
  output wb_req_t    s_req,
  output logic       m0_ack,
  output logic       m0_rty,
  output logic       m1_ack,
  output logic       m1_rty
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can
    // leave one unassigned and infer a latch.
    s_req  = '0;
    m0_ack = 1'b0;
    m0_rty = 1'b0;
    m1_ack = 1'b0;
    m1_rty = 1'b0;
    case (state)
      GRANT0: begin
        s_req  = m0_req;
        m0_ack = s_ack;
        m0_rty = s_rty;
      end
      GRANT1: begin
        s_req  = m1_req;
        m1_ack = s_ack;
        m1_rty = s_rty;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester round-robin wishbone arbiter: icache (m0) and eviction
// write-back (m1) share one memory-side bus, one transfer per grant.
module wb_arbiter
  import lc3b_types::*;
(
  input  logic    clk,
  input  logic    rst,

  input  wb_adr_t m0_ADR,
  input  wb_dat_t m0_DAT_M,
  input  wb_sel_t m0_SEL,
  input  logic    m0_STB,
  input  logic    m0_CYC,
  input  logic    m0_WE,
  output logic    m0_ACK,
  output logic    m0_RTY,
  output wb_dat_t m0_DAT_S,

  input  wb_adr_t m1_ADR,
  input  wb_dat_t m1_DAT_M,
  input  wb_sel_t m1_SEL,
  input  logic    m1_STB,
  input  logic    m1_CYC,
  input  logic    m1_WE,
  output logic    m1_ACK,
  output logic    m1_RTY,
  output wb_dat_t m1_DAT_S,

  output wb_adr_t s_ADR,
  output wb_dat_t s_DAT_M,
  output wb_sel_t s_SEL,
  output logic    s_STB,
  output logic    s_CYC,
  output logic    s_WE,
  input  wb_dat_t s_DAT_S,
  input  logic    s_ACK,
  input  logic    s_RTY
);

  arb_state_t state, state_next;
  logic       last_grant;
  wb_req_t    m0_req, m1_req, s_req;
  logic       req0, req1;

  assign m0_req = '{adr: m0_ADR, dat: m0_DAT_M, sel: m0_SEL,
                    we: m0_WE, stb: m0_STB, cyc: m0_CYC};
  assign m1_req = '{adr: m1_ADR, dat: m1_DAT_M, sel: m1_SEL,
                    we: m1_WE, stb: m1_STB, cyc: m1_CYC};

  assign req0 = wb_request(m0_req);
  assign req1 = wb_request(m1_req);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = last_grant ? GRANT0 : GRANT1;
        else if (req0)    state_next = GRANT0;
        else if (req1)    state_next = GRANT1;
      end
      // A grant ends on any memory response or when the owner abandons CYC.
      GRANT0: if (s_ACK || s_RTY || !m0_CYC) state_next = IDLE;
      GRANT1: if (s_ACK || s_RTY || !m1_CYC) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == GRANT0) last_grant <= 1'b0;
      else if (state_next == GRANT1) last_grant <= 1'b1;
    end
  end

  wb_arb_mux u_mux (
    .state  (state),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .s_ack  (s_ACK),
    .s_rty  (s_RTY),
    .s_req  (s_req),
    .m0_ack (m0_ACK),
    .m0_rty (m0_RTY),
    .m1_ack (m1_ACK),
    .m1_rty (m1_RTY)
  );

  assign s_ADR   = s_req.adr;
  assign s_DAT_M = s_req.dat;
  assign s_SEL   = s_req.sel;
  assign s_WE    = s_req.we;
  assign s_STB   = s_req.stb;
  assign s_CYC   = s_req.cyc;

  assign m0_DAT_S = s_DAT_S;
  assign m1_DAT_S = s_DAT_S;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed transfers push expected grants and
// responses; a monitor pops and compares whenever the bus shows them.
module tb_wb_arbiter;
  import lc3b_types::*;

  logic    clk = 1'b0;
  logic    rst;
  wb_adr_t m0_ADR, m1_ADR, s_ADR;
  wb_dat_t m0_DAT_M, m1_DAT_M, s_DAT_M, m0_DAT_S, m1_DAT_S, s_DAT_S;
  wb_sel_t m0_SEL, m1_SEL, s_SEL;
  logic    m0_STB, m0_CYC, m0_WE, m0_ACK, m0_RTY;
  logic    m1_STB, m1_CYC, m1_WE, m1_ACK, m1_RTY;
  logic    s_STB, s_CYC, s_WE, s_ACK, s_RTY;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_ADR(m0_ADR), .m0_DAT_M(m0_DAT_M), .m0_SEL(m0_SEL), .m0_STB(m0_STB),
    .m0_CYC(m0_CYC), .m0_WE(m0_WE), .m0_ACK(m0_ACK), .m0_RTY(m0_RTY),
    .m0_DAT_S(m0_DAT_S),
    .m1_ADR(m1_ADR), .m1_DAT_M(m1_DAT_M), .m1_SEL(m1_SEL), .m1_STB(m1_STB),
    .m1_CYC(m1_CYC), .m1_WE(m1_WE), .m1_ACK(m1_ACK), .m1_RTY(m1_RTY),
    .m1_DAT_S(m1_DAT_S),
    .s_ADR(s_ADR), .s_DAT_M(s_DAT_M), .s_SEL(s_SEL), .s_STB(s_STB),
    .s_CYC(s_CYC), .s_WE(s_WE), .s_DAT_S(s_DAT_S), .s_ACK(s_ACK), .s_RTY(s_RTY)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    wb_adr_t adr;
    logic    we;
    wb_sel_t sel;
    wb_dat_t dat;
  } grant_t;

  // flags = {m0_ACK, m1_ACK, m0_RTY, m1_RTY}
  typedef struct {
    logic [3:0] flags;
    wb_dat_t    dat;
  } resp_t;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];

  // Memory-side model: responds after mem_delay busy cycles; 0 stalls forever.
  int      mem_delay = 1;
  bit      mem_rty   = 1'b0;
  wb_dat_t mem_rdata = '0;
  int      mem_cnt   = 0;

  assign s_DAT_S = mem_rdata;

  initial begin
    s_ACK = 1'b0;
    s_RTY = 1'b0;
    forever begin
      @(negedge clk);
      if (s_STB && s_CYC && !s_ACK && !s_RTY) begin
        mem_cnt++;
        if (mem_delay != 0 && mem_cnt >= mem_delay) begin
          s_ACK = !mem_rty;
          s_RTY = mem_rty;
        end
      end else begin
        s_ACK   = 1'b0;
        s_RTY   = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  // Monitor: a new memory-side strobe pops a grant, any ACK/RTY pops a response.
  logic   prev_busy = 1'b0;
  logic   chk_idle  = 1'b0;
  logic   busy;
  logic [3:0] flags;
  grant_t g;
  resp_t  r;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      busy  = s_STB && s_CYC;
      flags = {m0_ACK, m1_ACK, m0_RTY, m1_RTY};
      if (chk_idle) begin
        check("idle_after_resp", 128'({s_CYC, s_STB, flags}), 128'(0));
        chk_idle = 1'b0;
      end
      if (busy && !prev_busy) begin
        if (exp_grant.size() == 0) begin
          check("grant_expected", 128'(exp_grant.size()), 128'(1));
        end else begin
          g = exp_grant.pop_front();
          check("grant_adr", 128'(s_ADR), 128'(g.adr));
          check("grant_we", 128'(s_WE), 128'(g.we));
          check("grant_sel", 128'(s_SEL), 128'(g.sel));
          check("grant_dat_m", s_DAT_M, g.dat);
        end
      end
      if (flags != 4'b0000) begin
        if (exp_resp.size() == 0) begin
          check("resp_expected", 128'(exp_resp.size()), 128'(1));
        end else begin
          r = exp_resp.pop_front();
          check("resp_flags", 128'(flags), 128'(r.flags));
          check("resp_m0_dat_s", m0_DAT_S, r.dat);
          check("resp_m1_dat_s", m1_DAT_S, r.dat);
        end
        chk_idle = 1'b1;
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic on, input wb_adr_t adr, input logic we,
                       input wb_sel_t sel, input wb_dat_t dat);
    if (k == 0) begin
      m0_CYC = on; m0_STB = on; m0_WE = on & we;
      m0_ADR = on ? adr : '0; m0_SEL = on ? sel : '0; m0_DAT_M = on ? dat : '0;
    end else begin
      m1_CYC = on; m1_STB = on; m1_WE = on & we;
      m1_ADR = on ? adr : '0; m1_SEL = on ? sel : '0; m1_DAT_M = on ? dat : '0;
    end
  endtask

  task automatic wait_resp(input int k, output bit rty);
    bit done = 1'b0;
    rty = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #2;
      if (k == 0 ? (m0_ACK || m0_RTY) : (m1_ACK || m1_RTY)) begin
        done = 1'b1;
        rty  = (k == 0) ? m0_RTY : m1_RTY;
      end
    end
    check($sformatf("m%0d_resp_timeout", k), 128'(done), 128'(1));
  endtask

  task automatic xfer(input int k, input wb_adr_t adr, input logic we, input wb_sel_t sel,
                      input wb_dat_t dat, output bit rty);
    tick();
    drive(k, 1'b1, adr, we, sel, dat);
    wait_resp(k, rty);
    tick();
    drive(k, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_grant(input wb_adr_t adr, input logic we, input wb_sel_t sel,
                              input wb_dat_t dat);
    grant_t e;
    e.adr = adr; e.we = we; e.sel = sel; e.dat = dat;
    exp_grant.push_back(e);
  endtask

  task automatic expect_resp(input logic [3:0] fl, input wb_dat_t dat);
    resp_t e;
    e.flags = fl; e.dat = dat;
    exp_resp.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    repeat (3) tick();
    check("reset_ctrl", 128'({s_CYC, s_STB, s_WE, m0_ACK, m1_ACK, m0_RTY, m1_RTY}), 128'(0));
    check("reset_adr", 128'(s_ADR), 128'(0));
    rst = 1'b0;
  endtask

  localparam wb_dat_t PAT_A5 = {16{8'hA5}};
  localparam wb_dat_t PAT_3C = {16{8'h3C}};
  localparam wb_dat_t WR_D0  = {4{32'hDEAD_0001}};
  localparam wb_dat_t WR_D1  = {4{32'hCAFE_0002}};

  initial begin
    bit rty;
    wb_dat_t wd;
    do_reset();

    // Single m0 read, memory responds on the third grant cycle.
    mem_delay = 3; mem_rdata = PAT_A5;
    expect_grant(12'h012, 1'b0, 16'hFFFF, '0);
    expect_resp(4'b1000, PAT_A5);
    tick();
    drive(0, 1'b1, 12'h012, 1'b0, 16'hFFFF, '0);
    #1 check("latency_idle_stb", 128'(s_STB), 128'(0));
    tick();
    check("latency_grant_stb", 128'(s_STB), 128'(1));
    wait_resp(0, rty);
    tick();
    drive(0, 1'b0, '0, 1'b0, '0, '0);

    // last_grant is now 0, so contention goes to m1 first.
    mem_delay = 1; mem_rdata = PAT_3C;
    expect_grant(12'h0B1, 1'b1, 16'hFFFF, WR_D1);
    expect_grant(12'h0A0, 1'b0, 16'hFFFF, '0);
    expect_resp(4'b0100, PAT_3C);
    expect_resp(4'b1000, PAT_3C);
    fork
      begin bit r0; xfer(0, 12'h0A0, 1'b0, 16'hFFFF, '0, r0); end
      begin bit r1; xfer(1, 12'h0B1, 1'b1, 16'hFFFF, WR_D1, r1); end
    join

    // After reset, simultaneous requests go to m0 then m1.
    do_reset();
    mem_delay = 2; mem_rdata = PAT_A5;
    expect_grant(12'h020, 1'b0, 16'hFFFF, '0);
    expect_grant(12'h030, 1'b1, 16'hF0F0, WR_D0);
    expect_resp(4'b1000, PAT_A5);
    expect_resp(4'b0100, PAT_A5);
    fork
      begin bit r0; xfer(0, 12'h020, 1'b0, 16'hFFFF, '0, r0); end
      begin bit r1; xfer(1, 12'h030, 1'b1, 16'hF0F0, WR_D0, r1); end
    join

    // Three back-to-back transfers each: grants alternate 0,1,0,1,0,1.
    mem_delay = 1;
    for (int i = 0; i < 3; i++) begin
      expect_grant(12'h100 + 12'(i), 1'b0, 16'hFFFF, '0);
      expect_resp(4'b1000, PAT_A5);
      expect_grant(12'h200 + 12'(i), 1'b1, 16'h0F0F, WR_D1);
      expect_resp(4'b0100, PAT_A5);
    end
    fork
      begin
        bit r0;
        for (int i = 0; i < 3; i++) xfer(0, 12'h100 + 12'(i), 1'b0, 16'hFFFF, '0, r0);
      end
      begin
        bit r1;
        for (int j = 0; j < 3; j++) xfer(1, 12'h200 + 12'(j), 1'b1, 16'h0F0F, WR_D1, r1);
      end
    join

    // m1 partial write is retried by memory, then reissued and acknowledged.
    mem_rty = 1'b1; mem_delay = 2;
    wd = {64'h0, 64'h0123_4567_89AB_CDEF};
    expect_grant(12'h3FF, 1'b1, 16'h00FF, wd);
    expect_resp(4'b0001, PAT_A5);
    xfer(1, 12'h3FF, 1'b1, 16'h00FF, wd, rty);
    check("m1_rty_seen", 128'(rty), 128'(1));
    mem_rty = 1'b0;
    expect_grant(12'h3FF, 1'b1, 16'h00FF, wd);
    expect_resp(4'b0100, PAT_A5);
    xfer(1, 12'h3FF, 1'b1, 16'h00FF, wd, rty);
    check("m1_reissue_ack", 128'(rty), 128'(0));

    // m0 aborts its stalled grant; the waiting m1 is served after one IDLE.
    mem_delay = 0;
    expect_grant(12'h044, 1'b0, 16'hFFFF, '0);
    expect_grant(12'h055, 1'b1, 16'hFFFF, WR_D0);
    expect_resp(4'b0100, PAT_A5);
    tick();
    drive(0, 1'b1, 12'h044, 1'b0, 16'hFFFF, '0);
    tick();
    drive(1, 1'b1, 12'h055, 1'b1, 16'hFFFF, WR_D0);
    tick();
    m0_CYC = 1'b0;
    #1 check("abort_s_cyc", 128'(s_CYC), 128'(0));
    tick();
    m0_STB = 1'b0;
    check("abort_idle_stb", 128'(s_STB), 128'(0));
    tick();
    check("abort_m1_granted_adr", 128'({s_STB, s_ADR}), 128'({1'b1, 12'h055}));
    mem_delay = 1;
    wait_resp(1, rty);
    tick();
    drive(1, 1'b0, '0, 1'b0, '0, '0);

    // Reset in the middle of a stalled m1 grant, then contention favours m0.
    mem_delay = 0;
    expect_grant(12'h066, 1'b0, 16'hFFFF, '0);
    tick();
    drive(1, 1'b1, 12'h066, 1'b0, 16'hFFFF, '0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    check("midreset_ctrl", 128'({s_CYC, s_STB, s_WE, m0_ACK, m1_ACK, m0_RTY, m1_RTY}), 128'(0));
    mem_delay = 2;
    expect_grant(12'h077, 1'b0, 16'hFFFF, '0);
    expect_grant(12'h088, 1'b1, 16'hFFFF, WR_D1);
    expect_resp(4'b1000, PAT_A5);
    expect_resp(4'b0100, PAT_A5);
    fork
      begin bit r0; xfer(0, 12'h077, 1'b0, 16'hFFFF, '0, r0); end
      begin bit r1; xfer(1, 12'h088, 1'b1, 16'hFFFF, WR_D1, r1); end
    join

    repeat (4) tick();
    check("grants_outstanding", 128'(exp_grant.size()), 128'(0));
    check("resps_outstanding", 128'(exp_resp.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
